// File: rtl/tlb_pkg.sv
// Shared definitions for the set-associative TLB storage.
// Width defaults, VPN index/tag split and the resp_way width helper.
package tlb_pkg;

  localparam int VPN_W_DEF = 27;
  localparam int PPN_W_DEF = 44;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [63:0] vpn_index(
    input logic [63:0] vpn,
    input int          idx_w
  );
    return vpn & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] vpn_tag(
    input logic [63:0] vpn,
    input int          idx_w
  );
    return vpn >> idx_w;
  endfunction

endpackage

// File: rtl/tlb_set_array_if.sv
// Lookup, response, fill and flush bundle between the
// translation front end / page walker and the TLB storage.
interface tlb_set_array_if
  import tlb_pkg::*;
#(
  parameter int VPN_W = VPN_W_DEF,
  parameter int PPN_W = PPN_W_DEF,
  parameter int WAY_W = 1
);
  logic             lookup_valid;
  logic [VPN_W-1:0] lookup_vpn;
  logic             resp_valid;
  logic             resp_hit;
  logic [PPN_W-1:0] resp_ppn;
  logic [WAY_W-1:0] resp_way;
  logic             fill_valid;
  logic [VPN_W-1:0] fill_vpn;
  logic [PPN_W-1:0] fill_ppn;
  logic             flush;

  modport master (
    output lookup_valid, lookup_vpn,
    output fill_valid, fill_vpn, fill_ppn,
    output flush,
    input  resp_valid, resp_hit,
    input  resp_ppn, resp_way
  );

  modport slave (
    input  lookup_valid, lookup_vpn,
    input  fill_valid, fill_vpn, fill_ppn,
    input  flush,
    output resp_valid, resp_hit,
    output resp_ppn, resp_way
  );
endinterface

// File: rtl/tlb_victim_sel.sv
// Picks the way a fill writes in one set: matching way, else
// lowest invalid way, else the round-robin way (which advances).
module tlb_victim_sel #(
  parameter int WAYS  = 2,
  parameter int WAY_W = 1
) (
  input  logic [WAYS-1:0]  valid_i,
  input  logic [WAYS-1:0]  match_i,
  input  logic [WAY_W-1:0] rr_i,
  output logic [WAY_W-1:0] way_o,
  output logic             adv_o
);
  logic [WAY_W-1:0] mway;
  logic [WAY_W-1:0] iway;

  always_comb begin
    mway = '0;
    iway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match_i[w])  mway = WAY_W'(w);
      if (!valid_i[w]) iway = WAY_W'(w);
    end
  end

  always_comb begin
    way_o = rr_i;
    adv_o = 1'b0;
    if (|match_i) begin
      way_o = mway;
    end else if (!(&valid_i)) begin
      way_o = iway;
    end else begin
      adv_o = 1'b1;
    end
  end
endmodule

// File: rtl/tlb_set_array.sv
// SETS x WAYS TLB storage with registered lookup response,
// victim-selected fill and global flush.
module tlb_set_array
  import tlb_pkg::*;
#(
  parameter int VPN_W = VPN_W_DEF,
  parameter int PPN_W = PPN_W_DEF,
  parameter int SETS  = 4,
  parameter int WAYS  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  tlb_set_array_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = VPN_W - IDX_W;
  localparam int WAY_W = clog2_min1(WAYS);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PPN_W-1:0] ppn;
  } entry_t;

  entry_t           ent_q [SETS][WAYS];
  logic [WAY_W-1:0] rr_q  [SETS];

  logic             resp_valid_q;
  logic             resp_hit_q, resp_hit_d;
  logic [PPN_W-1:0] resp_ppn_q, resp_ppn_d;
  logic [WAY_W-1:0] resp_way_q, resp_way_d;

  logic [IDX_W-1:0] l_idx, f_idx;
  logic [TAG_W-1:0] l_tag, f_tag;
  logic [WAYS-1:0]  f_valid, f_match;
  logic [WAY_W-1:0] f_way, rr_d;
  logic             f_adv;

  assign l_idx = IDX_W'(vpn_index(64'(bus.lookup_vpn), IDX_W));
  assign l_tag = TAG_W'(vpn_tag(64'(bus.lookup_vpn), IDX_W));
  assign f_idx = IDX_W'(vpn_index(64'(bus.fill_vpn), IDX_W));
  assign f_tag = TAG_W'(vpn_tag(64'(bus.fill_vpn), IDX_W));

  always_comb begin
    resp_hit_d = 1'b0;
    resp_ppn_d = '0;
    resp_way_d = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ent_q[l_idx][w].valid && ent_q[l_idx][w].tag == l_tag) begin
        resp_hit_d = 1'b1;
        resp_ppn_d = ent_q[l_idx][w].ppn;
        resp_way_d = WAY_W'(w);
      end
    end
  end

  always_comb begin
    f_valid = '0;
    f_match = '0;
    for (int w = 0; w < WAYS; w++) begin
      f_valid[w] = ent_q[f_idx][w].valid;
      f_match[w] = ent_q[f_idx][w].valid
                   && ent_q[f_idx][w].tag == f_tag;
    end
  end

  tlb_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_victim (
    .valid_i (f_valid),
    .match_i (f_match),
    .rr_i    (rr_q[f_idx]),
    .way_o   (f_way),
    .adv_o   (f_adv)
  );

  // Explicit wrap keeps WAYS=1 correct despite the 1-bit minimum width.
  assign rr_d = (rr_q[f_idx] == WAY_W'(WAYS - 1))
                ? '0 : rr_q[f_idx] + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) ent_q[s][w].valid <= 1'b0;
      end
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_ppn_q   <= '0;
      resp_way_q   <= '0;
    end else begin
      if (bus.flush) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) ent_q[s][w].valid <= 1'b0;
      end else if (bus.fill_valid) begin
        ent_q[f_idx][f_way] <= '{valid: 1'b1, tag: f_tag,
                                 ppn: bus.fill_ppn};
        if (f_adv) rr_q[f_idx] <= rr_d;
      end
      resp_valid_q <= bus.lookup_valid;
      if (bus.lookup_valid) begin
        resp_hit_q <= resp_hit_d;
        resp_ppn_q <= resp_ppn_d;
        resp_way_q <= resp_way_d;
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_ppn   = resp_ppn_q;
  assign bus.resp_way   = resp_way_q;
endmodule

// File: tb/tb_tlb_set_array.sv
// Directed bench for tlb_set_array, SETS=4 WAYS=2.
// Expected values are hand-derived from the fill/replace rules.
module tb_tlb_set_array;
  import tlb_pkg::*;

  localparam int VPN_W = 27;
  localparam int PPN_W = 44;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  tlb_set_array_if #(
    .VPN_W (VPN_W),
    .PPN_W (PPN_W),
    .WAY_W (1)
  ) bus ();

  tlb_set_array #(
    .VPN_W (VPN_W),
    .PPN_W (PPN_W),
    .SETS  (4),
    .WAYS  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.lookup_valid = 1'b0;
    bus.lookup_vpn   = '0;
    bus.fill_valid   = 1'b0;
    bus.fill_vpn     = '0;
    bus.fill_ppn     = '0;
    bus.flush        = 1'b0;
  endtask

  task automatic fill(input logic [63:0] vpn, input logic [63:0] ppn);
    bus.fill_valid = 1'b1;
    bus.fill_vpn   = VPN_W'(vpn);
    bus.fill_ppn   = PPN_W'(ppn);
    cyc();
    idle();
  endtask

  task automatic look(input string tag, input logic [63:0] vpn,
                      input logic hit, input logic [63:0] ppn,
                      input logic [63:0] way);
    bus.lookup_valid = 1'b1;
    bus.lookup_vpn   = VPN_W'(vpn);
    cyc();
    idle();
    chk({tag, ".vld"}, 64'(bus.resp_valid), 64'd1);
    chk({tag, ".hit"}, 64'(bus.resp_hit), 64'(hit));
    chk({tag, ".ppn"}, 64'(bus.resp_ppn), ppn);
    chk({tag, ".way"}, 64'(bus.resp_way), way);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst.vld", 64'(bus.resp_valid), 64'd0);
    chk("rst.hit", 64'(bus.resp_hit), 64'd0);
    chk("rst.ppn", 64'(bus.resp_ppn), 64'd0);
    chk("rst.way", 64'(bus.resp_way), 64'd0);
    rst_n = 1'b1;

    look("empty", 'h10, 1'b0, 'h0, 0);

    fill('h10, 'hAB);
    look("f10", 'h10, 1'b1, 'hAB, 0);
    fill('h14, 'hCD);
    look("f14", 'h14, 1'b1, 'hCD, 1);

    cyc();
    chk("hold.vld", 64'(bus.resp_valid), 64'd0);
    chk("hold.ppn", 64'(bus.resp_ppn), 64'hCD);
    chk("hold.way", 64'(bus.resp_way), 64'd1);

    fill('h18, 'h11);
    look("rr0", 'h18, 1'b1, 'h11, 0);
    look("ev10", 'h10, 1'b0, 'h0, 0);
    fill('h1C, 'h33);
    look("rr1", 'h1C, 1'b1, 'h33, 1);
    look("ev14", 'h14, 1'b0, 'h0, 0);

    fill('h18, 'h22);
    look("upd18", 'h18, 1'b1, 'h22, 0);
    look("keep1c", 'h1C, 1'b1, 'h33, 1);

    // Pointer still 0 after the in-place update, so 0x20 takes way 0.
    bus.fill_valid   = 1'b1;
    bus.fill_vpn     = VPN_W'('h20);
    bus.fill_ppn     = PPN_W'('h5);
    look("rbw20", 'h20, 1'b0, 'h0, 0);
    look("hit20", 'h20, 1'b1, 'h5, 0);
    look("ev18", 'h18, 1'b0, 'h0, 0);
    look("still1c", 'h1C, 1'b1, 'h33, 1);

    fill('h21, 'h77);
    look("set1", 'h21, 1'b1, 'h77, 0);

    bus.flush      = 1'b1;
    bus.fill_valid = 1'b1;
    bus.fill_vpn   = VPN_W'('h25);
    bus.fill_ppn   = PPN_W'('h99);
    look("preflush", 'h1C, 1'b1, 'h33, 1);
    look("fl20", 'h20, 1'b0, 'h0, 0);
    look("fl1c", 'h1C, 1'b0, 'h0, 0);
    look("fl21", 'h21, 1'b0, 'h0, 0);
    look("fl25", 'h25, 1'b0, 'h0, 0);

    // Set 0 pointer survived the flush at 1.
    fill('h10, 'h1);
    fill('h14, 'h2);
    fill('h18, 'h3);
    look("rrkeep", 'h18, 1'b1, 'h3, 1);
    look("rrkeep10", 'h10, 1'b1, 'h1, 0);

    bus.lookup_valid = 1'b1;
    bus.lookup_vpn   = VPN_W'('h10);
    cyc();
    chk("pend.vld", 64'(bus.resp_valid), 64'd1);
    rst_n = 1'b0;
    cyc();
    idle();
    chk("rstpend.vld", 64'(bus.resp_valid), 64'd0);
    chk("rstpend.ppn", 64'(bus.resp_ppn), 64'd0);
    rst_n = 1'b1;
    look("postrst", 'h10, 1'b0, 'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tlb_set_array.md
Name: tlb_set_array

Overview:
- Parametrised set-associative TLB storage: SETS sets × WAYS ways, each entry {valid, tag, ppn}.
- Successor to the fixed single-set block storage. Adds tag compare, hit/miss response, fill with victim selection, and global flush.
- Sits between the address-translation front end (lookup requests) and the page-walker (fills).

Parameters:
- VPN_W, 27, virtual page number width.
- PPN_W, 44, physical page number width.
- SETS, 4, number of sets; power of two, ≥2.
- WAYS, 2, ways per set; power of two, ≥1.
- IDX_W, log2(SETS), derived; set index width.
- TAG_W, VPN_W-IDX_W, derived; stored tag width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- lookup_valid  in  1  lookup request this cycle.
- lookup_vpn  in  VPN_W  VPN to translate.
- resp_valid  out  1  response valid; exactly one cycle after the accepted lookup.
- resp_hit  out  1  1 = hit, 0 = miss; qualified by resp_valid.
- resp_ppn  out  PPN_W  PPN of the hitting way; 0 on miss.
- resp_way  out  log2(WAYS) (min 1)  hitting way index; 0 on miss.
- fill_valid  in  1  write a translation this cycle.
- fill_vpn  in  VPN_W  VPN of the fill.
- fill_ppn  in  PPN_W  PPN of the fill.
- flush  in  1  invalidate all entries.

Behaviour:
- Reset (rst_n=0 at posedge):
  - All valid bits cleared.
  - All round-robin pointers set to 0.
  - resp_valid, resp_hit, resp_ppn, resp_way all 0.
  - Tag/ppn arrays need not be cleared.
- Address split: index = vpn[IDX_W-1:0]; tag = vpn[VPN_W-1:IDX_W].
- Lookup:
  - Always accepted; no backpressure.
  - Registered response with 1-cycle latency. resp_valid in cycle N+1 equals lookup_valid in cycle N.
  - Hit = any way in the indexed set has valid && tag match. More than one matching way cannot occur (see Fill).
  - resp_* fields hold their values while resp_valid=0.
- Fill, in the indexed set, in this priority order:
  1. If a valid way already has a matching tag, overwrite its ppn in place. Pointer unchanged.
  2. Else write the lowest-index invalid way. Pointer unchanged.
  3. Else replace the way given by the set's round-robin pointer, then increment the pointer modulo WAYS (wraps WAYS-1 → 0).
  - Written way becomes valid at the posedge. Fill is single-cycle; no handshake.
- Flush: clears all valid bits at the posedge. Round-robin pointers are not reset.
- Same-cycle events:
  - Lookup + fill (any set): lookup sees pre-fill contents (read-before-write). A lookup to the filled VPN in that cycle reports miss.
  - Lookup + flush: lookup sees pre-flush contents.
  - Fill + flush: flush wins; the fill is dropped and no pointer update occurs.
  - Reset overrides everything, including a response pending from the previous cycle (resp_valid=0 in the cycle after reset).
- No combinational path from inputs to outputs.

Decomposition:
- Shared package/header tlb_pkg:
  - VPN_W/PPN_W defaults.
  - Entry field layout {valid, tag, ppn}.
  - Index/tag extraction functions.
  - clog2 helper with min-1 width for resp_way.
- One sub-module: tlb_victim_sel. Combinational, per accessed set.
  - Inputs: valid vector, match vector, rr pointer.
  - Outputs: way to write, and a pointer-advance flag.

Test Plan (SETS=4, WAYS=2):
- Reset, then lookup vpn=0x10 → next cycle resp_valid=1, resp_hit=0, resp_ppn=0.
- Fill vpn=0x10 ppn=0xAB; lookup 0x10 next cycle → resp_hit=1, resp_ppn=0xAB, resp_way=0. Fill 0x14 ppn=0xCD (same set 0) → lands in way 1.
- Set 0 full (0x10, 0x14): fill 0x18 ppn=0x11 → replaces way 0 (ptr 0→1); fill 0x1C → replaces way 1 (ptr wraps to 0). Lookup 0x10 → miss.
- Refill 0x18 with ppn=0x22 → same way updated in place, no duplicate; lookup 0x18 → ppn=0x22; pointer unchanged.
- Lookup 0x20 and fill 0x20 ppn=0x5 in the same cycle → miss. Lookup 0x20 next cycle → hit ppn=0x5.
- Fill + flush in the same cycle, then lookups of all previously filled VPNs → all miss. Assert rst_n=0 with a lookup pending → resp_valid=0 the next cycle.
